// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: multi-digit hex-to-seven-segment controller.
// Accepts an N-nibble value through a valid/ready handshake and decodes it one
// digit per cycle through a single shared decoder into per-digit segment
// registers. Digits can blink from a free-running divider.
// Optional macro HEX_LZB_EN enables leading-zero blanking at write time.
// Segments are active-low, bit order g..a = [6..0].
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*NUM_DIGITS-1:0]   in_value,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic                      done,
    output logic [7*NUM_DIGITS-1:0]   hex_out
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    typedef enum logic {
        IDLE,
        UPDATE
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [4*NUM_DIGITS-1:0]   shadow;
    logic [7*NUM_DIGITS-1:0]   seg;
    logic [6:0]                wr_pattern;
    logic [CNT_W-1:0]          blink_cnt;
    logic                      blink_phase;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b1000000;
            4'h1: p = 7'b1111001;
            4'h2: p = 7'b0100100;
            4'h3: p = 7'b0110000;
            4'h4: p = 7'b0011001;
            4'h5: p = 7'b0010010;
            4'h6: p = 7'b0000010;
            4'h7: p = 7'b1111000;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0010000;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b0000011;
            4'hC: p = 7'b1000110;
            4'hD: p = 7'b0100001;
            4'hE: p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

`ifdef HEX_LZB_EN
    logic [4*NUM_DIGITS-1:0] upper;
`endif

    // Shared decoder: pattern for the digit currently being written
    always_comb begin
        wr_pattern = seg7(shadow[idx*4 +: 4]);
`ifdef HEX_LZB_EN
        // Digit idx and everything above it zero -> leading zero, blank it
        upper = shadow >> (idx*4);
        if (idx != '0 && upper == '0) begin
            wr_pattern = '1;
        end
`endif
    end

    // Handshake FSM: capture value, then write one digit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
            idx      <= '0;
            shadow   <= '0;
            seg      <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shadow   <= in_value;
                        idx      <= '0;
                        state    <= UPDATE;
                        in_ready <= 1'b0;
                    end
                end
                UPDATE: begin
                    seg[idx*7 +: 7] <= wr_pattern;
                    if (idx == LAST_IDX) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running blink divider; phase toggles on each counter wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Output: blank blinking digits during the active phase
    always_comb begin
        hex_out = seg;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (blink_mask[i] && blink_phase) begin
                hex_out[i*7 +: 7] = '1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed self-checking bench for hex_display_ctrl
// (NUM_DIGITS=4, BLINK_DIV=4). Honours HEX_LZB_EN the same way as the design.
module tb_hex_display_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic [3:0]  blink_mask;
    logic        done;
    logic [27:0] hex_out;

    int checks = 0;
    int errors = 0;
    logic [27:0] shown;

    localparam logic [6:0] BL = 7'b1111111;

    hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .blink_mask (blink_mask),
        .done       (done),
        .hex_out    (hex_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a value for one edge and confirm it is taken
    task automatic accept(input logic [15:0] v);
        check_eq("ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_value = v;
        tick();
        in_valid = 1'b0;
        check_eq("ready_low_after_accept", {31'd0, in_ready}, 32'd0);
        check_eq("done_low_after_accept", {31'd0, done}, 32'd0);
    endtask

    // Follow the four write edges: digit k-1 becomes new after edge k
    task automatic watch_update(input logic [27:0] fin);
        logic [27:0] e;
        for (int k = 1; k <= 4; k++) begin
            tick();
            e = shown;
            for (int d = 0; d < k; d++) e[d*7 +: 7] = fin[d*7 +: 7];
            check_eq("update_hex", {4'd0, hex_out}, {4'd0, e});
            check_eq("update_ready", {31'd0, in_ready}, {31'd0, k == 4});
            check_eq("update_done", {31'd0, done}, {31'd0, k == 4});
        end
        shown = fin;
    endtask

    initial begin
        logic [27:0] e;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_value   = 16'h0;
        blink_mask = 4'b0;
        shown      = '1;

        // Reset held two cycles
        tick();
        tick();
        rst = 1'b0;
        check_eq("reset_hex", {4'd0, hex_out}, 32'h0FFFFFFF);
        check_eq("reset_ready", {31'd0, in_ready}, 32'd1);
        check_eq("reset_done", {31'd0, done}, 32'd0);

        // 0x1234
        accept(16'h1234);
        watch_update({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        tick();
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);
        check_eq("idle_ready", {31'd0, in_ready}, 32'd1);

        // 0xABCD with 0xFFFF held valid during the update
        accept(16'hABCD);
        in_valid = 1'b1;
        in_value = 16'hFFFF;
        watch_update({7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001});
        tick();
        in_valid = 1'b0;
        check_eq("held_accept_ready", {31'd0, in_ready}, 32'd0);
        check_eq("held_accept_hex", {4'd0, hex_out}, {4'd0, shown});
        watch_update({4{7'b0001110}});
        tick();

        // 0x0050
        accept(16'h0050);
`ifdef HEX_LZB_EN
        watch_update({BL, BL, 7'b0010010, 7'b1000000});
`else
        watch_update({7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000});
`endif
        tick();

        // 0x0000
        accept(16'h0000);
`ifdef HEX_LZB_EN
        watch_update({BL, BL, BL, 7'b1000000});
`else
        watch_update({4{7'b1000000}});
`endif
        tick();

        // 0x5678 aborted by reset after two digits
        accept(16'h5678);
        tick();
        e = shown;
        e[6:0] = 7'b0000000;
        check_eq("abort_digit0", {4'd0, hex_out}, {4'd0, e});
        tick();
        e[13:7] = 7'b1111000;
        check_eq("abort_digit1", {4'd0, hex_out}, {4'd0, e});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_hex", {4'd0, hex_out}, 32'h0FFFFFFF);
        check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("abort_no_done", {31'd0, done}, 32'd0);
            check_eq("abort_stays_blank", {4'd0, hex_out}, 32'h0FFFFFFF);
        end
        shown = '1;

        // Blink: reset aligns the divider; phase after reset edge k is (k/4)%2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        accept(16'h8888);
        watch_update({4{7'b0000000}});
        blink_mask = 4'b0101;
        for (int k = 5; k < 21; k++) begin
            #1;
            if (((k / 4) % 2) == 1)
                e = {7'b0000000, BL, 7'b0000000, BL};
            else
                e = '0;
            check_eq("blink_hex", {4'd0, hex_out}, {4'd0, e});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
